// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state type and slice width for the nibble-serial adder
package nibble_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_adder_adder_1b.sv
// adder_1b: combinational 4-bit ripple-carry slice
module adder_1b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one nibble per cycle through a shared 4-bit slice
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end
  nsa_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d, res_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic cout_q, cout_d, ovf_q, ovf_d;
  logic [NIBBLE_W-1:0] s_sum;
  logic s_carry;
  adder_1b u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (s_sum),
    .carry(s_carry)
  );
  // result fills from the top so the first nibble lands at bit 0 after NIB shifts
  assign res_nx    = {s_sum, res_q[WIDTH-1:NIBBLE_W]};
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        a_msb_d = a[WIDTH-1];
        b_msb_d = b[WIDTH-1];
        state_d = RUN;
      end
      RUN: begin
        res_d   = res_nx;
        carry_d = s_carry;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_nx;
          cout_d  = s_carry;
          ovf_d   = (a_msb_q == b_msb_q) && (res_nx[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
